// File: rtl/goe_cfg_pkg.sv
// Shared configuration for the GOE table loader: table ids, widths, default depths,
// FSM encoding and the table-id to write-enable decode.
package goe_cfg_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 2;

   localparam int unsigned DEPTH0_DEFAULT = 65536;
   localparam int unsigned DEPTH1_DEFAULT = 65536;
   localparam int unsigned DEPTH2_DEFAULT = 16;

   localparam logic [1:0] TBL_S0  = 2'd0;
   localparam logic [1:0] TBL_S1  = 2'd1;
   localparam logic [1:0] TBL_S2  = 2'd2;
   localparam logic [1:0] TBL_ALL = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StDone
   } state_e;

   function automatic logic [2:0] tbl_onehot(input logic [1:0] tbl);
      logic [2:0] we;
      unique case (tbl)
         TBL_S0:  we = 3'b001;
         TBL_S1:  we = 3'b010;
         TBL_S2:  we = 3'b100;
         default: we = 3'b000;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/goe_table_loader_if.sv
// Control/write-port bundle between the register bank (master) and the table loader (slave).
interface goe_table_loader_if;

   logic                                start;
   logic                                abort;
   logic [1:0]                          table_sel;
   logic [goe_cfg_pkg::ADDR_W-1:0]      in_mask;
   logic [4:0]                          thr0;
   logic [4:0]                          thr1;
   logic [2:0]                          tbl_we;
   logic [goe_cfg_pkg::ADDR_W-1:0]      tbl_waddr;
   logic [goe_cfg_pkg::DATA_W-1:0]      tbl_wdata;
   logic                                busy;
   logic                                done;
   logic                                aborted;

   modport master (
      output start, abort, table_sel, in_mask, thr0, thr1,
      input  tbl_we, tbl_waddr, tbl_wdata, busy, done, aborted
   );

   modport slave (
      input  start, abort, table_sel, in_mask, thr0, thr1,
      output tbl_we, tbl_waddr, tbl_wdata, busy, done, aborted
   );

endinterface

// File: rtl/goe_popcount16.sv
// Registered 16-bit population count; result valid one cycle after data_i.
module goe_popcount16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] data_i,
   output logic [4:0]  cnt_o
);

   logic [4:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < 16; i++) begin
         cnt_d = cnt_d + 5'(data_i[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/goe_table_loader.sv
// Sweeps the selected GOE tables and writes popcount-threshold entries through a
// two-stage pipeline (popcount, then compare + registered write port).
module goe_table_loader
   import goe_cfg_pkg::*;
#(
   parameter int unsigned DEPTH0 = DEPTH0_DEFAULT,
   parameter int unsigned DEPTH1 = DEPTH1_DEFAULT,
   parameter int unsigned DEPTH2 = DEPTH2_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   goe_table_loader_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(DEPTH0 - 1);
   localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(DEPTH1 - 1);
   localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(DEPTH2 - 1);

   state_e              state_q, state_d;
   logic [1:0]          sel_q, sel_d, cur_tbl_q, cur_tbl_d;
   logic [ADDR_W-1:0]   mask_q, mask_d, addr_q, addr_d;
   logic [4:0]          thr0_q, thr0_d, thr1_q, thr1_d;
   logic                flush_cnt_q, flush_cnt_d;
   logic                p1_vld_q, p1_vld_d;
   logic [1:0]          p1_tbl_q, p1_tbl_d;
   logic [ADDR_W-1:0]   p1_addr_q, p1_addr_d;
   logic [2:0]          we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
   logic [4:0]          cnt;
   logic [ADDR_W-1:0]   last_addr;
   logic                issue;

   goe_popcount16 u_popcount (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .data_i (addr_q & mask_q),
      .cnt_o  (cnt)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cur_tbl_d   = cur_tbl_q;
      mask_d      = mask_q;
      addr_d      = addr_q;
      thr0_d      = thr0_q;
      thr1_d      = thr1_q;
      flush_cnt_d = flush_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      issue       = 1'b0;

      unique case (cur_tbl_q)
         TBL_S0:  last_addr = LAST0;
         TBL_S1:  last_addr = LAST1;
         default: last_addr = LAST2;
      endcase

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.abort) begin
               sel_d     = bus.table_sel;
               cur_tbl_d = (bus.table_sel == TBL_ALL) ? TBL_S0 : bus.table_sel;
               mask_d    = bus.in_mask;
               thr0_d    = bus.thr0;
               thr1_d    = bus.thr1;
               addr_d    = '0;
               busy_d    = 1'b1;
               state_d   = StRun;
            end
         end
         StRun: begin
            issue = 1'b1;
            if (addr_q == last_addr) begin
               addr_d = '0;
               // Chained loads roll straight into the next table without a bubble.
               if (sel_q == TBL_ALL && cur_tbl_q != TBL_S2) begin
                  cur_tbl_d = cur_tbl_q + 2'd1;
               end else begin
                  flush_cnt_d = 1'b0;
                  state_d     = StFlush;
               end
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         StFlush: begin
            if (flush_cnt_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               flush_cnt_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      p1_vld_d  = issue;
      p1_tbl_d  = cur_tbl_q;
      p1_addr_d = addr_q;
      we_d      = p1_vld_q ? tbl_onehot(p1_tbl_q) : 3'b000;
      waddr_d   = p1_vld_q ? p1_addr_q : '0;
      wdata_d   = p1_vld_q ? {cnt >= thr1_q, cnt >= thr0_q} : '0;

      // Abort kills everything in flight so no partial write escapes.
      if (bus.abort && (state_q == StRun || state_q == StFlush)) begin
         state_d   = StIdle;
         addr_d    = '0;
         busy_d    = 1'b0;
         aborted_d = 1'b1;
         p1_vld_d  = 1'b0;
         we_d      = 3'b000;
         waddr_d   = '0;
         wdata_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sel_q       <= TBL_S0;
         cur_tbl_q   <= TBL_S0;
         mask_q      <= '0;
         addr_q      <= '0;
         thr0_q      <= '0;
         thr1_q      <= '0;
         flush_cnt_q <= 1'b0;
         p1_vld_q    <= 1'b0;
         p1_tbl_q    <= TBL_S0;
         p1_addr_q   <= '0;
         we_q        <= 3'b000;
         waddr_q     <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cur_tbl_q   <= cur_tbl_d;
         mask_q      <= mask_d;
         addr_q      <= addr_d;
         thr0_q      <= thr0_d;
         thr1_q      <= thr1_d;
         flush_cnt_q <= flush_cnt_d;
         p1_vld_q    <= p1_vld_d;
         p1_tbl_q    <= p1_tbl_d;
         p1_addr_q   <= p1_addr_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   assign bus.tbl_we    = we_q;
   assign bus.tbl_waddr = waddr_q;
   assign bus.tbl_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;

endmodule
